cf_fft_addr_seq: RTL and testbench

Parametrised radix-2 FFT address sequencer: the successor to the fixed 9-bit, single-level loop counter used in the FFT control chain. It runs a nested stage/butterfly loop for an N = 2^LOG2N point in-place FFT. Each butterfly produces a registered (addr_a, addr_b, twiddle) triple, with end-of-stage and end-of-transform flags. It sits between the FFT top-level controller (start/abort/advance) and the data/twiddle memory address ports.

---
 rtl/cf_fft_addr_seq.sv | 163 ++++++++++++++++
 tb/tb_cf_fft_addr_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_fft_addr_seq.sv
// Radix-2 decimation-in-frequency FFT address sequencer.
// Walks stage s = 0..LOG2N-1 and butterfly b = 0..N/2-1. For each accepted
// advance it emits a registered (addr_a, addr_b, twiddle) triple, and it
// flags the final butterfly of each stage and the end of the transform.
module cf_fft_addr_seq #(
  parameter int unsigned LOG2N = 10,
  parameter int unsigned SW    = $clog2(LOG2N)
) (
  input  logic             clock_c,
  input  logic             reset,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [SW-1:0]    stage_o,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam logic [SW-1:0] S_MAX = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [LOG2N-2:0] b_q, b_d;
  logic             fin_q, fin_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic [SW-1:0]    p;
  logic [LOG2N-1:0] bit_p, low_mask, b_ext, low, ins_a, ins_b, tw_full;
  logic [LOG2N-2:0] tw_cur;

  // DIF address/twiddle for the current (s, b): insert a 0 at bit p = LOG2N-1-s
  always_comb begin
    p        = S_MAX - s_q;
    bit_p    = {{(LOG2N-1){1'b0}}, 1'b1} << p;
    low_mask = bit_p - LOG2N'(1);
    b_ext    = {1'b0, b_q};
    low      = b_ext & low_mask;
    ins_a    = ((b_ext & ~low_mask) << 1) | low;
    ins_b    = ins_a | bit_p;
    tw_full  = low << s_q;
    tw_cur   = tw_full[LOG2N-2:0];
  end

  // Next-state, loop counters and output-register inputs
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    b_d      = b_q;
    fin_d    = fin_q;
    stage_d  = stage_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tw_d     = tw_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      s_d     = '0;
      b_d     = '0;
      fin_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
            s_d     = '0;
            b_d     = '0;
            fin_d   = 1'b0;
          end
        end
        ST_RUN: begin
          // fin_q marks that the final triple is on the outputs now; DONE
          // follows one cycle later so done_o never overlaps valid_o.
          if (fin_q) begin
            state_d = ST_DONE;
            fin_d   = 1'b0;
          end else if (enable_i) begin
            stage_d  = s_q;
            addr_a_d = ins_a;
            addr_b_d = ins_b;
            tw_d     = tw_cur;
            valid_d  = 1'b1;
            last_d   = (b_q == '1);
            if (b_q != '1) begin
              b_d = b_q + (LOG2N-1)'(1);
            end else if (s_q != S_MAX) begin
              b_d = '0;
              s_d = s_q + SW'(1);
            end else begin
              b_d   = '0;
              s_d   = '0;
              fin_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state_d = ST_RUN;
            s_d     = '0;
            b_d     = '0;
            fin_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clock_c) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      b_q      <= '0;
      fin_q    <= 1'b0;
      stage_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      b_q      <= b_d;
      fin_q    <= fin_d;
      stage_q  <= stage_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign stage_o  = stage_q;
  assign addr_a_o = addr_a_q;
  assign addr_b_o = addr_b_q;
  assign tw_o     = tw_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign done_o   = (state_q == ST_DONE);
  assign busy_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_cf_fft_addr_seq.sv
// Directed bench for cf_fft_addr_seq at LOG2N=3 and LOG2N=10.
module tb_cf_fft_addr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LOG2N = 3 instance
  logic       rst3, start3, clear3, en3;
  logic [1:0] stage3;
  logic [2:0] a3, b3;
  logic [1:0] tw3;
  logic       valid3, last3, done3, busy3;

  cf_fft_addr_seq #(.LOG2N(3)) dut3 (
    .clock_c(clk), .reset(rst3), .start_i(start3), .clear_i(clear3),
    .enable_i(en3), .stage_o(stage3), .addr_a_o(a3), .addr_b_o(b3),
    .tw_o(tw3), .valid_o(valid3), .last_o(last3), .done_o(done3),
    .busy_o(busy3)
  );

  // LOG2N = 10 instance
  logic       rst10, start10, clear10, en10;
  logic [3:0] stage10;
  logic [9:0] a10, b10;
  logic [8:0] tw10;
  logic       valid10, last10, done10, busy10;

  cf_fft_addr_seq #(.LOG2N(10)) dut10 (
    .clock_c(clk), .reset(rst10), .start_i(start10), .clear_i(clear10),
    .enable_i(en10), .stage_o(stage10), .addr_a_o(a10), .addr_b_o(b10),
    .tw_o(tw10), .valid_o(valid10), .last_o(last10), .done_o(done10),
    .busy_o(busy10)
  );

  int checks = 0;
  int errors = 0;
  int v3     = 0;

  // Hand-computed LOG2N=3 sequence
  int exp_s [12] = '{0,0,0,0, 1,1,1,1, 2,2,2,2};
  int exp_a [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
  int exp_b [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
  int exp_tw[12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};
  int exp_l [12] = '{0,0,0,1, 0,0,0,1, 0,0,0,1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (valid3 === 1'b1) v3++;
  endtask

  task automatic chk_beat(input int i);
    chk($sformatf("valid[%0d]", i), 32'(valid3), 32'(1));
    chk($sformatf("stage[%0d]", i), 32'(stage3), 32'(exp_s[i]));
    chk($sformatf("addr_a[%0d]", i), 32'(a3), 32'(exp_a[i]));
    chk($sformatf("addr_b[%0d]", i), 32'(b3), 32'(exp_b[i]));
    chk($sformatf("tw[%0d]", i), 32'(tw3), 32'(exp_tw[i]));
    chk($sformatf("last[%0d]", i), 32'(last3), 32'(exp_l[i]));
    chk($sformatf("done_beat[%0d]", i), 32'(done3), 32'(0));
  endtask

  initial begin
    int  cnt;
    bit  seen_done;
    logic [3:0] ls;
    logic [9:0] la, lb;
    logic [8:0] ltw;

    rst3 = 1'b1; start3 = 1'b0; clear3 = 1'b0; en3 = 1'b0;
    rst10 = 1'b1; start10 = 1'b0; clear10 = 1'b0; en10 = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_stage", 32'(stage3), 32'(0));
    chk("rst_a", 32'(a3), 32'(0));
    chk("rst_b", 32'(b3), 32'(0));
    chk("rst_tw", 32'(tw3), 32'(0));
    chk("rst_valid", 32'(valid3), 32'(0));
    chk("rst_last", 32'(last3), 32'(0));
    chk("rst_done", 32'(done3), 32'(0));
    chk("rst_busy", 32'(busy3), 32'(0));
    rst3 = 1'b0; rst10 = 1'b0;
    tick();

    // Full run, enable held high
    v3 = 0;
    start3 = 1'b1; en3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("run_busy", 32'(busy3), 32'(1));
    chk("run_first_valid", 32'(valid3), 32'(0));
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_beat(i);
    end
    tick();
    chk("run_done", 32'(done3), 32'(1));
    chk("run_done_valid", 32'(valid3), 32'(0));
    chk("run_done_busy", 32'(busy3), 32'(0));
    tick();
    chk("run_done_pulse", 32'(done3), 32'(0));
    chk("run_idle_busy", 32'(busy3), 32'(0));
    chk("run_beats", 32'(v3), 32'(12));

    // Back-pressure: enable 1,0,0 repeating
    en3 = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en3 = 1'b1;
      tick();
      chk_beat(i);
      en3 = 1'b0;
      tick();
      if (i == 11) begin
        chk("bp_done", 32'(done3), 32'(1));
        chk("bp_done_valid", 32'(valid3), 32'(0));
        tick();
        chk("bp_done_pulse", 32'(done3), 32'(0));
      end else begin
        chk($sformatf("bp_gap_valid[%0d]", i), 32'(valid3), 32'(0));
        chk($sformatf("bp_hold_a[%0d]", i), 32'(a3), 32'(exp_a[i]));
        tick();
        chk($sformatf("bp_gap2_valid[%0d]", i), 32'(valid3), 32'(0));
        chk($sformatf("bp_busy[%0d]", i), 32'(busy3), 32'(1));
      end
    end

    // Abort in stage 1 at b=2
    en3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_beat(i);
    end
    clear3 = 1'b1;
    tick();
    clear3 = 1'b0;
    chk("abort_valid", 32'(valid3), 32'(0));
    chk("abort_busy", 32'(busy3), 32'(0));
    chk("abort_done", 32'(done3), 32'(0));
    tick();
    chk("abort_done2", 32'(done3), 32'(0));
    chk("abort_valid2", 32'(valid3), 32'(0));
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    chk_beat(0);
    clear3 = 1'b1;
    tick();
    clear3 = 1'b0;

    // start and clear together in IDLE
    start3 = 1'b1; clear3 = 1'b1;
    tick();
    start3 = 1'b0; clear3 = 1'b0;
    chk("sc_busy", 32'(busy3), 32'(0));
    tick();
    chk("sc_busy2", 32'(busy3), 32'(0));
    chk("sc_valid", 32'(valid3), 32'(0));

    // Back-to-back, start held high through RUN (ignored) and DONE
    v3 = 0;
    start3 = 1'b1; en3 = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_beat(i);
    end
    tick();
    chk("b2b_done", 32'(done3), 32'(1));
    tick();
    chk("b2b_done_pulse", 32'(done3), 32'(0));
    chk("b2b_gap_valid", 32'(valid3), 32'(0));
    chk("b2b_busy", 32'(busy3), 32'(1));
    tick();
    chk_beat(0);
    start3 = 1'b0;
    for (int i = 1; i < 12; i++) begin
      tick();
      chk_beat(i);
    end
    tick();
    chk("b2b_done2", 32'(done3), 32'(1));
    tick();
    chk("b2b_idle", 32'(busy3), 32'(0));
    chk("b2b_beats", 32'(v3), 32'(24));

    // Wide config: full run
    cnt = 0; seen_done = 1'b0;
    ls = '0; la = '0; lb = '0; ltw = '0;
    start10 = 1'b1; en10 = 1'b1;
    tick();
    start10 = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (valid10 === 1'b1) begin
        cnt++;
        ls = stage10; la = a10; lb = b10; ltw = tw10;
        if (cnt == 1) begin
          chk("w_first_a", 32'(a10), 32'(0));
          chk("w_first_b", 32'(b10), 32'(512));
        end
        if (cnt == 2) begin
          chk("w_second_a", 32'(a10), 32'(1));
          chk("w_second_b", 32'(b10), 32'(513));
          chk("w_second_tw", 32'(tw10), 32'(1));
        end
        if (cnt == 514) begin
          chk("w_s1b1_stage", 32'(stage10), 32'(1));
          chk("w_s1b1_a", 32'(a10), 32'(1));
          chk("w_s1b1_b", 32'(b10), 32'(257));
          chk("w_s1b1_tw", 32'(tw10), 32'(2));
        end
      end
      if (done10 === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk("w_done_seen", 32'(seen_done), 32'(1));
    chk("w_beats", 32'(cnt), 32'(5120));
    chk("w_last_stage", 32'(ls), 32'(9));
    chk("w_last_a", 32'(la), 32'(1022));
    chk("w_last_b", 32'(lb), 32'(1023));
    chk("w_last_tw", 32'(ltw), 32'(0));
    tick();

    // Wide config: reset mid-RUN
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("w_mid_valid", 32'(valid10), 32'(1));
    rst10 = 1'b1;
    tick();
    rst10 = 1'b0;
    chk("w_rst_stage", 32'(stage10), 32'(0));
    chk("w_rst_a", 32'(a10), 32'(0));
    chk("w_rst_b", 32'(b10), 32'(0));
    chk("w_rst_tw", 32'(tw10), 32'(0));
    chk("w_rst_valid", 32'(valid10), 32'(0));
    chk("w_rst_last", 32'(last10), 32'(0));
    chk("w_rst_done", 32'(done10), 32'(0));
    chk("w_rst_busy", 32'(busy10), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
